hazard_stall_unit: RTL and testbench



---
 rtl/hazard_stall_unit.sv | 170 +++++++++++++++++
 tb/tb_hazard_stall_unit.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_stall_unit.sv
// Pipeline hazard/stall controller: load-use bubbles, multi-cycle FP occupancy of EX, taken-branch flush.
// Optional HAZARD_STATS_EN adds saturating stall/flush event counters.
module hazard_stall_unit #(
    parameter int FP_LATENCY = 3,
    parameter int CNT_W      = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] if_id_opcode,
    input  logic [4:0] if_id_rs,
    input  logic [4:0] if_id_rt,
    input  logic       id_ex_mem_read,
    input  logic [4:0] id_ex_rt,
    input  logic       id_ex_fp,
    input  logic       branch_taken,
    output logic       control_mux_select,
    output logic       pc_write,
    output logic       if_id_write,
    output logic       if_id_flush,
    output logic       id_ex_hold,
    output logic [1:0] stall_state
`ifdef HAZARD_STATS_EN
    ,
    output logic [15:0] load_stall_cnt,
    output logic [15:0] fp_stall_cnt,
    output logic [15:0] flush_cnt
`endif
);

    typedef enum logic [1:0] {
        IDLE       = 2'b00,
        LOAD_STALL = 2'b01,
        FP_BUSY    = 2'b10,
        UNUSED     = 2'b11
    } state_e;

    localparam bit              FP_EN     = (FP_LATENCY > 1);
    localparam int              FP_LAT_M2 = (FP_LATENCY > 1) ? (FP_LATENCY - 2) : 0;
    localparam logic [CNT_W-1:0] FP_INIT  = CNT_W'(FP_LAT_M2);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rt_used_s;
    logic             load_use_s;
    logic             load_stall_s;

    // Hazard detection: rt only matters for formats that actually read it
    always_comb begin
        case (if_id_opcode)
            6'd0, 6'd17, 6'd43, 6'd4: rt_used_s = 1'b1;
            default:                  rt_used_s = 1'b0;
        endcase
        load_use_s = id_ex_mem_read && (id_ex_rt != 5'd0) &&
                     ((id_ex_rt == if_id_rs) || (rt_used_s && (id_ex_rt == if_id_rt)));
    end

    // Next-state and Mealy outputs; priority is branch > FP > load-use
    always_comb begin
        state_d            = state_q;
        cnt_d              = cnt_q;
        control_mux_select = 1'b0;
        pc_write           = 1'b1;
        if_id_write        = 1'b1;
        if_id_flush        = 1'b0;
        id_ex_hold         = 1'b0;
        load_stall_s       = 1'b0;
        if (reset) begin
            control_mux_select = 1'b1;
            pc_write           = 1'b0;
            if_id_write        = 1'b0;
            state_d            = IDLE;
            cnt_d              = '0;
        end else if (branch_taken) begin
            control_mux_select = 1'b1;
            if_id_flush        = 1'b1;
            state_d            = IDLE;
            cnt_d              = '0;
        end else begin
            case (state_q)
                IDLE, LOAD_STALL: begin
                    if (id_ex_fp && FP_EN) begin
                        control_mux_select = 1'b1;
                        pc_write           = 1'b0;
                        if_id_write        = 1'b0;
                        id_ex_hold         = 1'b1;
                        cnt_d              = FP_INIT;
                        state_d            = FP_BUSY;
                    end else if (load_use_s) begin
                        control_mux_select = 1'b1;
                        pc_write           = 1'b0;
                        if_id_write        = 1'b0;
                        load_stall_s       = 1'b1;
                        state_d            = LOAD_STALL;
                    end else begin
                        state_d = IDLE;
                    end
                end
                FP_BUSY: begin
                    // cnt == 0 is the release cycle; id_ex_fp is deliberately ignored here
                    if (cnt_q != '0) begin
                        control_mux_select = 1'b1;
                        pc_write           = 1'b0;
                        if_id_write        = 1'b0;
                        id_ex_hold         = 1'b1;
                        cnt_d              = cnt_q - CNT_W'(1);
                    end else begin
                        cnt_d   = '0;
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // State and FP occupancy counter
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign stall_state = state_q;

`ifdef HAZARD_STATS_EN
    logic [15:0] load_stall_cnt_q, load_stall_cnt_d;
    logic [15:0] fp_stall_cnt_q, fp_stall_cnt_d;
    logic [15:0] flush_cnt_q, flush_cnt_d;

    function automatic logic [15:0] sat_inc(input logic [15:0] v, input logic en);
        if (en && (v != 16'hFFFF)) begin
            return v + 16'd1;
        end else begin
            return v;
        end
    endfunction

    // Saturating event counters
    always_comb begin
        load_stall_cnt_d = sat_inc(load_stall_cnt_q, load_stall_s);
        fp_stall_cnt_d   = sat_inc(fp_stall_cnt_q, id_ex_hold);
        flush_cnt_d      = sat_inc(flush_cnt_q, if_id_flush);
    end

    // Counter registers, cleared by reset
    always_ff @(posedge clk) begin
        if (reset) begin
            load_stall_cnt_q <= 16'd0;
            fp_stall_cnt_q   <= 16'd0;
            flush_cnt_q      <= 16'd0;
        end else begin
            load_stall_cnt_q <= load_stall_cnt_d;
            fp_stall_cnt_q   <= fp_stall_cnt_d;
            flush_cnt_q      <= flush_cnt_d;
        end
    end

    assign load_stall_cnt = load_stall_cnt_q;
    assign fp_stall_cnt   = fp_stall_cnt_q;
    assign flush_cnt      = flush_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Self-checking bench for hazard_stall_unit: four instances (FP_LATENCY 3,1,4,5) share stimulus and
// are compared against a behavioural stall model, plus a directed vector table and corner sequences.
module tb_hazard_stall_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic [5:0] if_id_opcode;
    logic [4:0] if_id_rs, if_id_rt, id_ex_rt;
    logic       id_ex_mem_read, id_ex_fp, branch_taken;

    logic [3:0] cms_w, pcw_w, ifw_w, fl_w, hold_w;
    logic [1:0] st_w [4];
`ifdef HAZARD_STATS_EN
    logic [15:0] lsc_w [4];
    logic [15:0] fsc_w [4];
    logic [15:0] flc_w [4];
`endif

    function automatic int lat(input int k);
        return (k == 0) ? 3 : (k == 1) ? 1 : (k == 2) ? 4 : 5;
    endfunction

    for (genvar g = 0; g < 4; g++) begin : g_dut
        hazard_stall_unit #(.FP_LATENCY((g == 0) ? 3 : (g == 1) ? 1 : (g == 2) ? 4 : 5), .CNT_W(4)) u_dut (
            .clk               (clk),
            .reset             (reset),
            .if_id_opcode      (if_id_opcode),
            .if_id_rs          (if_id_rs),
            .if_id_rt          (if_id_rt),
            .id_ex_mem_read    (id_ex_mem_read),
            .id_ex_rt          (id_ex_rt),
            .id_ex_fp          (id_ex_fp),
            .branch_taken      (branch_taken),
            .control_mux_select(cms_w[g]),
            .pc_write          (pcw_w[g]),
            .if_id_write       (ifw_w[g]),
            .if_id_flush       (fl_w[g]),
            .id_ex_hold        (hold_w[g]),
            .stall_state       (st_w[g])
`ifdef HAZARD_STATS_EN
            ,
            .load_stall_cnt    (lsc_w[g]),
            .fp_stall_cnt      (fsc_w[g]),
            .flush_cnt         (flc_w[g])
`endif
        );
    end

    int n_checks = 0;
    int n_fail   = 0;

    // Model: remaining FP stall cycles (-1 = not busy, 0 = release cycle) and previous-cycle load stall
    int busy_left [4];
    bit last_load [4];

    task automatic chk(input string name, input logic [6:0] act, input logic [6:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got {cms,pcw,ifw,flush,hold,state}=%b expected %b", name, act, exp);
        end
    endtask

    function automatic logic [6:0] act_of(input int k, input bit mask_st);
        return {cms_w[k], pcw_w[k], ifw_w[k], fl_w[k], hold_w[k], mask_st ? 2'b00 : st_w[k]};
    endfunction

    function automatic bit lu();
        bit ru;
        ru = (if_id_opcode == 6'd0) || (if_id_opcode == 6'd17) || (if_id_opcode == 6'd43) || (if_id_opcode == 6'd4);
        return id_ex_mem_read && (id_ex_rt != 5'd0) && ((id_ex_rt == if_id_rs) || (ru && (id_ex_rt == if_id_rt)));
    endfunction

    function automatic logic [6:0] model_exp(input int k);
        logic [1:0] st;
        if (reset) return 7'b1000000;
        st = (busy_left[k] >= 0) ? 2'd2 : (last_load[k] ? 2'd1 : 2'd0);
        if (branch_taken)               return {5'b11110, st};
        if (busy_left[k] > 0)           return {5'b10001, st};
        if (busy_left[k] == 0)          return {5'b01100, st};
        if (id_ex_fp && (lat(k) > 1))   return {5'b10001, st};
        if (lu())                       return {5'b10000, st};
        return {5'b01100, st};
    endfunction

    task automatic model_step();
        bit l;
        l = lu();
        for (int k = 0; k < 4; k++) begin
            if (reset || branch_taken) begin
                busy_left[k] = -1; last_load[k] = 1'b0;
            end else if (busy_left[k] > 0) begin
                busy_left[k]--;
            end else if (busy_left[k] == 0) begin
                busy_left[k] = -1; last_load[k] = 1'b0;
            end else if (id_ex_fp && (lat(k) > 1)) begin
                busy_left[k] = lat(k) - 2; last_load[k] = 1'b0;
            end else begin
                last_load[k] = l;
            end
        end
    endtask

    task automatic check_all(input string tag);
        for (int k = 0; k < 4; k++) chk($sformatf("%s_d%0d", tag, k), act_of(k, reset), model_exp(k));
    endtask

    task automatic finish_cycle();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic tick(input string tag);
        #2;
        check_all(tag);
        finish_cycle();
    endtask

    task automatic hand(input string name, input int k, input bit chk_st, input logic [6:0] exp);
        #2;
        chk(name, act_of(k, !chk_st), exp);
        check_all(name);
        finish_cycle();
    endtask

    task automatic set_in(input bit r, input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                          input bit mr, input logic [4:0] ert, input bit fp, input bit br);
        reset = r; if_id_opcode = op; if_id_rs = rs; if_id_rt = rt;
        id_ex_mem_read = mr; id_ex_rt = ert; id_ex_fp = fp; branch_taken = br;
    endtask

    typedef struct {
        bit         rst;
        logic [5:0] op;
        logic [4:0] rs, rt;
        bit         mr;
        logic [4:0] ert;
        bit         fp, br;
        logic [6:0] exp;
        bit         chk_st;
    } vec_t;

    vec_t tbl [20];
    logic [5:0] ops [7];

    initial begin
        for (int k = 0; k < 4; k++) begin busy_left[k] = -1; last_load[k] = 1'b0; end
        ops = '{6'd0, 6'd17, 6'd43, 6'd4, 6'd8, 6'd35, 6'd2};

        // Expected values for the FP_LATENCY=3 instance, {cms,pcw,ifw,flush,hold,state}
        tbl[0]  = '{1'b1, 6'd0,  5'd5, 5'd0, 1'b1, 5'd5, 1'b1, 1'b0, 7'b1000000, 1'b0};
        tbl[1]  = '{1'b1, 6'd0,  5'd5, 5'd0, 1'b1, 5'd5, 1'b1, 1'b0, 7'b1000000, 1'b0};
        tbl[2]  = '{1'b0, 6'd0,  5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 7'b0110000, 1'b1};
        tbl[3]  = '{1'b0, 6'd0,  5'd5, 5'd0, 1'b1, 5'd5, 1'b0, 1'b0, 7'b1000000, 1'b1};
        tbl[4]  = '{1'b0, 6'd0,  5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 7'b0110001, 1'b1};
        tbl[5]  = '{1'b0, 6'd0,  5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 7'b0110000, 1'b1};
        tbl[6]  = '{1'b0, 6'd0,  5'd0, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0, 7'b0110000, 1'b1};
        tbl[7]  = '{1'b0, 6'd8,  5'd3, 5'd5, 1'b1, 5'd5, 1'b0, 1'b0, 7'b0110000, 1'b1};
        tbl[8]  = '{1'b0, 6'd43, 5'd3, 5'd5, 1'b1, 5'd5, 1'b0, 1'b0, 7'b1000000, 1'b1};
        tbl[9]  = '{1'b0, 6'd0,  5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 7'b0110001, 1'b1};
        tbl[10] = '{1'b0, 6'd0,  5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 7'b1000100, 1'b1};
        tbl[11] = '{1'b0, 6'd0,  5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 7'b1000110, 1'b1};
        tbl[12] = '{1'b0, 6'd0,  5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 7'b0110010, 1'b1};
        tbl[13] = '{1'b0, 6'd0,  5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 7'b0110000, 1'b1};
        tbl[14] = '{1'b0, 6'd0,  5'd5, 5'd0, 1'b1, 5'd5, 1'b0, 1'b1, 7'b1111000, 1'b1};
        tbl[15] = '{1'b0, 6'd0,  5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 7'b0110000, 1'b1};
        tbl[16] = '{1'b0, 6'd0,  5'd5, 5'd0, 1'b1, 5'd5, 1'b0, 1'b0, 7'b1000000, 1'b1};
        tbl[17] = '{1'b0, 6'd0,  5'd5, 5'd0, 1'b1, 5'd5, 1'b0, 1'b0, 7'b1000001, 1'b1};
        tbl[18] = '{1'b0, 6'd0,  5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 7'b0110001, 1'b1};
        tbl[19] = '{1'b0, 6'd0,  5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 7'b0110000, 1'b1};

        for (int i = 0; i < 20; i++) begin
            set_in(tbl[i].rst, tbl[i].op, tbl[i].rs, tbl[i].rt, tbl[i].mr, tbl[i].ert, tbl[i].fp, tbl[i].br);
            hand($sformatf("tbl%0d", i), 0, tbl[i].chk_st, tbl[i].exp);
        end

        // Branch in the second FP_BUSY cycle of the FP_LATENCY=4 instance, with a load-use also present
        set_in(1'b0, 6'd0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0); hand("br_fp_a", 2, 1'b1, 7'b1000100);
        hand("br_fp_b", 2, 1'b1, 7'b1000110);
        set_in(1'b0, 6'd0, 5'd5, 5'd0, 1'b1, 5'd5, 1'b1, 1'b1); hand("br_fp_c", 2, 1'b1, 7'b1111010);
        set_in(1'b0, 6'd0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0); hand("br_fp_d", 2, 1'b1, 7'b0110000);

        // Reset while the FP_LATENCY=5 instance is in FP_BUSY with cnt = 2
        set_in(1'b0, 6'd0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0); hand("rst_fp_a", 3, 1'b1, 7'b1000100);
        set_in(1'b0, 6'd0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0); hand("rst_fp_b", 3, 1'b1, 7'b1000110);
        set_in(1'b1, 6'd0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0); hand("rst_fp_c", 3, 1'b0, 7'b1000000);
        set_in(1'b0, 6'd0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
`ifdef HAZARD_STATS_EN
        #2;
        n_checks++;
        if (fsc_w[3] !== 16'd0) begin n_fail++; $display("FAIL fp_stall_cnt_after_reset: got %0d expected 0", fsc_w[3]); end
        #1;
`endif
        hand("rst_fp_d", 3, 1'b1, 7'b0110000);
        hand("rst_fp_e", 3, 1'b1, 7'b0110000);

        // FP_LATENCY=1 never stalls
        set_in(1'b0, 6'd17, 5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0); hand("fp1_a", 1, 1'b1, 7'b0110000);
        hand("fp1_b", 1, 1'b1, 7'b0110000);
        set_in(1'b0, 6'd0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0); tick("fp1_c");

        // Randomized traffic against the model, small register range to provoke hits
        for (int i = 0; i < 3000; i++) begin
            set_in(($urandom_range(0, 63) == 0), ops[$urandom_range(0, 6)], 5'($urandom_range(0, 3)),
                   5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
                   ($urandom_range(0, 7) == 0), ($urandom_range(0, 9) == 0));
            tick($sformatf("rnd%0d", i));
        end

`ifdef HAZARD_STATS_EN
        begin
            int budget;
            set_in(1'b1, 6'd0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
            @(posedge clk); #1;
            reset = 1'b0; id_ex_fp = 1'b1;
            budget = 0;
            while ((fsc_w[3] != 16'hFFFF) && (budget < 84000)) begin
                @(posedge clk); #1;
                budget++;
            end
            repeat (10) @(posedge clk);
            #1;
            n_checks++;
            if (fsc_w[3] !== 16'hFFFF) begin n_fail++; $display("FAIL fp_stall_cnt_sat: got %h expected ffff", fsc_w[3]); end
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
